// File: rtl/tag_array_pkg.sv
// Shared types and helpers for the N-way set-associative tag store.
// Provides the flush FSM state type, way-index width derivation and hit encoding.
package tag_array_pkg;

    localparam int DEF_WAYS  = 2;
    localparam int DEF_SETS  = 32;
    localparam int DEF_TAG_W = 22;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Lowest set bit wins, so an illegal multi-way match still yields a stable index.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag store: tag/valid storage, write port and lookup compare.
// Optional even-parity storage per entry when TAG_PARITY_EN is defined.
module tag_way_bank #(
    parameter int SETS  = 32,
    parameter int TAG_W = 22,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_index,
    input  logic             flush_en,
    input  logic [IDX_W-1:0] flush_index,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [TAG_W-1:0] cmp_tag,
    output logic             match,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic             par_err
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    logic             par_ok;

    // Invalidate is applied last so it wins over a fill of the same line.
    always_comb begin
        valid_d = valid_q;
        if (flush_en) valid_d[flush_index] = 1'b0;
        if (wr_en)    valid_d[wr_index]    = 1'b1;
        if (inv_en)   valid_d[inv_index]   = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    always_ff @(posedge CLK) begin
        if (wr_en) tag_q[wr_index] <= wr_tag;
    end

`ifdef TAG_PARITY_EN
    logic [SETS-1:0] par_q;

    always_ff @(posedge CLK) begin
        if (flush_en) par_q[flush_index] <= 1'b0;
        if (wr_en)    par_q[wr_index]    <= ^wr_tag;
    end

    assign par_ok = (par_q[rd_index] == ^tag_q[rd_index]);
`else
    assign par_ok = 1'b1;
`endif

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign match    = rd_valid && par_ok && (tag_q[rd_index] == cmp_tag);
    assign par_err  = rd_valid && !par_ok;

endmodule

// File: rtl/tag_array_nway.sv
// N-way set-associative tag store: registered lookup, fill/invalidate, round-robin
// victim pointers and a one-set-per-cycle flush. Parity option: TAG_PARITY_EN.
//
// state    | meaning
// ST_IDLE  | accepting lookups, fills, invalidates and flush requests
// ST_FLUSH | clearing set cnt_q each cycle; all requests ignored, busy high
module tag_array_nway
    import tag_array_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = DEF_TAG_W,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_index,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAY_W-1:0] rsp_way,
    output logic [WAY_W-1:0] rsp_victim_way,
    output logic             rsp_victim_valid,
    output logic [TAG_W-1:0] rsp_victim_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WAY_W-1:0] wr_way,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_index,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             flush_req,
    output logic             busy,
    output logic             parity_err
);

    state_t           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             busy_q;

    logic lk_acc, wr_acc, inv_acc, flush_en;
    assign lk_acc   = lk_valid && !busy_q;
    assign wr_acc   = wr_en    && !busy_q;
    assign inv_acc  = inv_en   && !busy_q;
    assign flush_en = (state_q == ST_FLUSH);

    logic [WAYS-1:0]  match_vec;
    logic [WAYS-1:0]  rd_valid_vec;
    logic [WAYS-1:0]  perr_vec;
    logic [TAG_W-1:0] rd_tag_arr [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_way_bank #(
            .SETS  (SETS),
            .TAG_W (TAG_W),
            .IDX_W (IDX_W)
        ) u_bank (
            .CLK         (CLK),
            .RSTn        (RSTn),
            .wr_en       (wr_acc && (wr_way == WAY_W'(w))),
            .wr_index    (wr_index),
            .wr_tag      (wr_tag),
            .inv_en      (inv_acc && (inv_way == WAY_W'(w))),
            .inv_index   (inv_index),
            .flush_en    (flush_en),
            .flush_index (cnt_q),
            .rd_index    (lk_index),
            .cmp_tag     (lk_tag),
            .match       (match_vec[w]),
            .rd_valid    (rd_valid_vec[w]),
            .rd_tag      (rd_tag_arr[w]),
            .par_err     (perr_vec[w])
        );
    end

    logic [WAY_W-1:0] vict_way;

    if (WAYS > 1) begin : g_ptr
        logic [WAY_W-1:0] ptr_q [SETS];

        // Pointer advances only when the fill consumes the current victim.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
            end else if (flush_en) begin
                ptr_q[cnt_q] <= '0;
            end else if (wr_acc && (wr_way == ptr_q[wr_index])) begin
                ptr_q[wr_index] <= ptr_q[wr_index] + 1'b1;
            end
        end

        assign vict_way = ptr_q[lk_index];
    end else begin : g_noptr
        assign vict_way = '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(SETS - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    assign hit_any = |match_vec;
    assign hit_way = WAY_W'(onehot_to_idx(8'(match_vec)));

    logic             rsp_valid_q, rsp_hit_q, rsp_vvalid_q, perr_q;
    logic [WAY_W-1:0] rsp_way_q, rsp_vway_q;
    logic [TAG_W-1:0] rsp_vtag_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_vway_q   <= '0;
            rsp_vvalid_q <= 1'b0;
            rsp_vtag_q   <= '0;
            perr_q       <= 1'b0;
        end else begin
            rsp_valid_q <= lk_acc;
            rsp_hit_q   <= lk_acc && hit_any;
            perr_q      <= lk_acc && (|perr_vec);
            if (lk_acc) begin
                rsp_way_q    <= hit_way;
                rsp_vway_q   <= vict_way;
                rsp_vvalid_q <= rd_valid_vec[vict_way];
                rsp_vtag_q   <= rd_tag_arr[vict_way];
            end
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_way          = rsp_way_q;
    assign rsp_victim_way   = rsp_vway_q;
    assign rsp_victim_valid = rsp_vvalid_q;
    assign rsp_victim_tag   = rsp_vtag_q;
    assign busy             = busy_q;
    assign parity_err       = perr_q;

endmodule

// File: tb/tb_tag_array_nway.sv
// Self-checking bench for tag_array_nway: directed table, flush/reset sequences
// and randomized traffic against an array-based reference model.
module tb_tag_array_nway;

    localparam int WAYS  = 2;
    localparam int SETS  = 32;
    localparam int TAG_W = 22;
    localparam int IDX_W = 5;
    localparam int WAY_W = 1;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             lk_valid, wr_en, inv_en, flush_req;
    logic [IDX_W-1:0] lk_index, wr_index, inv_index;
    logic [TAG_W-1:0] lk_tag, wr_tag;
    logic [WAY_W-1:0] wr_way, inv_way;
    logic             rsp_valid, rsp_hit, rsp_victim_valid, busy, parity_err;
    logic [WAY_W-1:0] rsp_way, rsp_victim_way;
    logic [TAG_W-1:0] rsp_victim_tag;

    always #5 CLK = ~CLK;

    tag_array_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .CLK              (CLK),
        .RSTn             (RSTn),
        .lk_valid         (lk_valid),
        .lk_index         (lk_index),
        .lk_tag           (lk_tag),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_way          (rsp_way),
        .rsp_victim_way   (rsp_victim_way),
        .rsp_victim_valid (rsp_victim_valid),
        .rsp_victim_tag   (rsp_victim_tag),
        .wr_en            (wr_en),
        .wr_index         (wr_index),
        .wr_way           (wr_way),
        .wr_tag           (wr_tag),
        .inv_en           (inv_en),
        .inv_index        (inv_index),
        .inv_way          (inv_way),
        .flush_req        (flush_req),
        .busy             (busy),
        .parity_err       (parity_err)
    );

    typedef struct {
        logic             lk;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic             wr;
        logic [IDX_W-1:0] widx;
        logic [WAY_W-1:0] wway;
        logic [TAG_W-1:0] wtag;
        logic             inv;
        logic [IDX_W-1:0] iidx;
        logic [WAY_W-1:0] iway;
        logic             fl;
        logic             e_valid;
        logic             e_hit;
        logic [WAY_W-1:0] e_way;
        logic [WAY_W-1:0] e_vway;
        logic             e_vvalid;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays of line state plus a remaining-busy count.
    logic             m_valid [SETS][WAYS];
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    int               m_ptr   [SETS];
    int               busy_left;

    logic             e_valid, e_hit, e_vvalid, e_busy;
    int               e_way, e_vway;
    logic [TAG_W-1:0] e_vtag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        busy_left = 0;
    endtask

    task automatic model_step(input vec_t v);
        e_valid = 1'b0;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (v.lk) begin
                e_valid = 1'b1;
                e_hit   = 1'b0;
                e_way   = 0;
                for (int w = 0; w < WAYS; w++) begin
                    if (!e_hit && m_valid[v.idx][w] && m_tag[v.idx][w] == v.tag) begin
                        e_hit = 1'b1;
                        e_way = w;
                    end
                end
                e_vway   = m_ptr[v.idx];
                e_vvalid = m_valid[v.idx][e_vway];
                e_vtag   = m_tag[v.idx][e_vway];
            end
            if (v.wr) begin
                m_tag[v.widx][v.wway]   = v.wtag;
                m_valid[v.widx][v.wway] = 1'b1;
                if (int'(v.wway) == m_ptr[v.widx]) m_ptr[v.widx] = (m_ptr[v.widx] + 1) % WAYS;
            end
            if (v.inv) m_valid[v.iidx][v.iway] = 1'b0;
            if (v.fl) begin
                for (int s = 0; s < SETS; s++) begin
                    m_ptr[s] = 0;
                    for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
                end
                busy_left = SETS;
            end
        end
        e_busy = (busy_left > 0);
    endtask

    function automatic vec_t nop();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        lk_valid  = v.lk;   lk_index  = v.idx;  lk_tag = v.tag;
        wr_en     = v.wr;   wr_index  = v.widx; wr_way = v.wway; wr_tag = v.wtag;
        inv_en    = v.inv;  inv_index = v.iidx; inv_way = v.iway;
        flush_req = v.fl;
        model_step(v);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input string tagname);
        chk({tagname, ".rsp_valid"}, rsp_valid, e_valid);
        chk({tagname, ".busy"}, busy, e_busy);
`ifndef TAG_PARITY_EN
        chk({tagname, ".parity_err"}, parity_err, 0);
`endif
        if (e_valid) begin
            chk({tagname, ".hit"}, rsp_hit, e_hit);
            chk({tagname, ".way"}, rsp_way, e_way);
            chk({tagname, ".victim_way"}, rsp_victim_way, e_vway);
            chk({tagname, ".victim_valid"}, rsp_victim_valid, e_vvalid);
            if (e_vvalid) chk({tagname, ".victim_tag"}, rsp_victim_tag, e_vtag);
        end
    endtask

    vec_t tbl [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   busy_cycles;

        apply_init: begin
            v = nop();
            lk_valid = 0; lk_index = 0; lk_tag = 0;
            wr_en = 0; wr_index = 0; wr_way = 0; wr_tag = 0;
            inv_en = 0; inv_index = 0; inv_way = 0; flush_req = 0;
        end
        model_reset();
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset.rsp_valid", rsp_valid, 0);
        chk("reset.rsp_hit", rsp_hit, 0);
        chk("reset.rsp_way", rsp_way, 0);
        chk("reset.victim_way", rsp_victim_way, 0);
        chk("reset.victim_valid", rsp_victim_valid, 0);
        chk("reset.busy", busy, 0);
        chk("reset.parity_err", parity_err, 0);
        RSTn = 1'b1;

        //         lk idx tag       wr widx wway wtag   inv iidx iway fl  ev eh ew evw evv
        tbl[0]  = '{1, 5, 'h12345, 0, 0,  0,   0,      0,  0,   0,   0,  1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,       1, 5,  0,   'h12345,0,  0,   0,   0,  0, 0, 0, 0, 0};
        tbl[2]  = '{1, 5, 'h12345, 0, 0,  0,   0,      0,  0,   0,   0,  1, 1, 0, 1, 0};
        tbl[3]  = '{1, 3, 'hA,     1, 3,  0,   'hA,    0,  0,   0,   0,  1, 0, 0, 0, 0};
        tbl[4]  = '{1, 3, 'hA,     0, 0,  0,   0,      0,  0,   0,   0,  1, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0,       1, 7,  0,   'h1,    0,  0,   0,   0,  0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0,       1, 7,  1,   'h2,    0,  0,   0,   0,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,       0, 0,  0,   0,      1,  7,   1,   0,  0, 0, 0, 0, 0};
        tbl[8]  = '{1, 7, 'h2,     0, 0,  0,   0,      0,  0,   0,   0,  1, 0, 0, 0, 1};
        tbl[9]  = '{1, 7, 'h1,     0, 0,  0,   0,      0,  0,   0,   0,  1, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 0,       1, 9,  1,   'h5,    0,  0,   0,   0,  0, 0, 0, 0, 0};
        tbl[11] = '{1, 9, 'h5,     0, 0,  0,   0,      0,  0,   0,   0,  1, 1, 1, 0, 0};
        tbl[12] = '{0, 0, 0,       1, 10, 1,   'h7,    1,  10,  1,   0,  0, 0, 0, 0, 0};
        tbl[13] = '{1, 10,'h7,     0, 0,  0,   0,      0,  0,   0,   0,  1, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0,       1, 11, 0,   'h3,    1,  11,  1,   0,  0, 0, 0, 0, 0};
        tbl[15] = '{1, 11,'h3,     0, 0,  0,   0,      0,  0,   0,   0,  1, 1, 0, 1, 0};

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d.rsp_valid", i), rsp_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.hit", i), rsp_hit, tbl[i].e_hit);
                chk($sformatf("tbl%0d.way", i), rsp_way, tbl[i].e_way);
                chk($sformatf("tbl%0d.victim_way", i), rsp_victim_way, tbl[i].e_vway);
                chk($sformatf("tbl%0d.victim_valid", i), rsp_victim_valid, tbl[i].e_vvalid);
            end
        end

        // Flush: busy for exactly SETS cycles, lookups ignored, then everything misses.
        for (int s = 0; s < 6; s++) begin
            v = nop(); v.wr = 1; v.widx = IDX_W'(s); v.wway = WAY_W'(s % 2); v.wtag = TAG_W'(s + 'h40);
            apply(v);
        end
        v = nop(); v.fl = 1;
        apply(v);
        chk("flush.busy_start", busy, 1);
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            v = nop(); v.lk = 1; v.idx = 5; v.tag = 'h12345; v.wr = 1; v.widx = 20; v.wtag = 'h99;
            apply(v);
            busy_cycles++;
            chk("flush.no_rsp", rsp_valid, 0);
        end
        chk("flush.busy_cycles", busy_cycles, SETS);
        for (int s = 0; s < 6; s++) begin
            v = nop(); v.lk = 1; v.idx = IDX_W'(s); v.tag = TAG_W'(s + 'h40);
            apply(v);
            check_model($sformatf("postflush%0d", s));
        end
        v = nop(); v.lk = 1; v.idx = 20; v.tag = 'h99;
        apply(v);
        check_model("postflush.ignored_fill");

        // Reset asserted in the middle of a flush.
        for (int s = 8; s < 10; s++) begin
            v = nop(); v.wr = 1; v.widx = IDX_W'(s); v.wway = 0; v.wtag = TAG_W'(s + 'h100);
            apply(v);
        end
        v = nop(); v.fl = 1;
        apply(v);
        for (int i = 0; i < 10; i++) apply(nop());
        chk("midreset.busy_before", busy, 1);
        RSTn = 1'b0;
        #1;
        chk("midreset.busy", busy, 0);
        chk("midreset.rsp_valid", rsp_valid, 0);
        model_reset();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            v = nop(); v.lk = 1; v.idx = IDX_W'(s); v.tag = TAG_W'(s + 'h100);
            apply(v);
            check_model($sformatf("midreset.set%0d", s));
        end

        // Randomized traffic over a few sets so hits, evictions and collisions are frequent.
        for (int i = 0; i < 600; i++) begin
            v = nop();
            v.lk   = 1'($urandom % 2);
            v.idx  = IDX_W'($urandom % 4);
            v.tag  = TAG_W'($urandom % 3);
            v.wr   = ($urandom % 3) == 0;
            v.widx = IDX_W'($urandom % 4);
            v.wway = WAY_W'($urandom % 2);
            v.wtag = TAG_W'($urandom % 3);
            v.inv  = ($urandom % 5) == 0;
            v.iidx = IDX_W'($urandom % 4);
            v.iway = WAY_W'($urandom % 2);
            v.fl   = ($urandom % 80) == 0;
            if (v.wr && v.inv && v.widx == v.iidx && v.wway == v.iway) v.inv = 0;
            apply(v);
            check_model($sformatf("rand%0d", i));
        end

`ifdef TAG_PARITY_EN
        begin
            while (busy) apply(nop());
            v = nop(); v.wr = 1; v.widx = 2; v.wway = 0; v.wtag = 'h5;
            apply(v);
            dut.g_way[0].u_bank.tag_q[2] = 'h4;
            v = nop(); v.lk = 1; v.idx = 2; v.tag = 'h4;
            apply(v);
            chk("parity.rsp_valid", rsp_valid, 1);
            chk("parity.hit", rsp_hit, 0);
            chk("parity.err", parity_err, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
